branch_unit: RTL and testbench

// - Branch/jump execution unit; consumer end of the BranchRS issue interface (Branch_* bundle).
// - Resolves B-type/JAL/JALR: computes taken, target and link value.
// - Results go into a 2-entry result queue, then onto the Branch CDB lane under the CDB arbiter's grant.
// - Consumers of the Branch CDB lane: RSs, LSB, ROB (ROB also takes taken/target for redirect/mispredict).

---
 rtl/branch_unit_pkg.sv | 18 +
 rtl/branch_resolve.sv | 59 +++++
 rtl/branch_unit.sv | 137 +++++++++++++
 tb/tb_branch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_unit_pkg.sv
// Shared widths and op codes for the branch execution unit and its resolver.
package branch_unit_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_TAG_W  = 4;
   localparam int DEF_OP_W   = 6;

   localparam logic [DEF_OP_W-1:0] OP_JAL  = 6'd1;
   localparam logic [DEF_OP_W-1:0] OP_JALR = 6'd2;
   localparam logic [DEF_OP_W-1:0] OP_BEQ  = 6'd3;
   localparam logic [DEF_OP_W-1:0] OP_BNE  = 6'd4;
   localparam logic [DEF_OP_W-1:0] OP_BLT  = 6'd5;
   localparam logic [DEF_OP_W-1:0] OP_BGE  = 6'd6;
   localparam logic [DEF_OP_W-1:0] OP_BLTU = 6'd7;
   localparam logic [DEF_OP_W-1:0] OP_BGEU = 6'd8;

endpackage

// File: rtl/branch_resolve.sv
// Pure combinational branch/jump resolver: op and operands in, taken/target/link out.
module branch_resolve
   import branch_unit_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int OP_W   = DEF_OP_W
) (
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] reg1,
   input  logic [DATA_W-1:0] reg2,
   input  logic [DATA_W-1:0] imm,
   input  logic [ADDR_W-1:0] pc,
   output logic              taken,
   output logic [ADDR_W-1:0] target,
   output logic [DATA_W-1:0] data
);

   logic [ADDR_W-1:0] seq_pc;
   logic [ADDR_W-1:0] br_pc;
   logic [ADDR_W-1:0] jalr_pc;
   logic              cond;

   assign seq_pc  = pc + ADDR_W'(4);
   assign br_pc   = pc + ADDR_W'(imm);
   assign jalr_pc = ADDR_W'(reg1 + imm) & ~ADDR_W'(1);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      cond   = 1'b0;
      taken  = 1'b0;
      target = seq_pc;
      data   = '0;
      case (op)
         OP_BEQ:  cond = (reg1 == reg2);
         OP_BNE:  cond = (reg1 != reg2);
         OP_BLT:  cond = ($signed(reg1) <  $signed(reg2));
         OP_BGE:  cond = ($signed(reg1) >= $signed(reg2));
         OP_BLTU: cond = (reg1 <  reg2);
         OP_BGEU: cond = (reg1 >= reg2);
         OP_JAL: begin
            taken  = 1'b1;
            target = br_pc;
            data   = DATA_W'(seq_pc);
         end
         OP_JALR: begin
            taken  = 1'b1;
            target = jalr_pc;
            data   = DATA_W'(seq_pc);
         end
         default: ;
      endcase
      if (cond) begin
         taken  = 1'b1;
         target = br_pc;
      end
   end

endmodule

// File: rtl/branch_unit.sv
// Branch execution unit: resolves issued branches/jumps and queues results (2 entries)
// for the Branch CDB lane, holding the head until the arbiter grants it.
module branch_unit
   import branch_unit_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int TAG_W  = DEF_TAG_W,
   parameter int OP_W   = DEF_OP_W,
   parameter int QDEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clear,
   input  logic              Branch_valid,
   input  logic [OP_W-1:0]   Branch_op,
   input  logic [DATA_W-1:0] Branch_reg1,
   input  logic [DATA_W-1:0] Branch_reg2,
   input  logic [DATA_W-1:0] Branch_imm,
   input  logic [ADDR_W-1:0] Branch_pc,
   input  logic [TAG_W-1:0]  Branch_reg_des_rob,
   output logic              bu_full,
   input  logic              cdb_grant,
   output logic              Branch_cdb_valid,
   output logic [TAG_W-1:0]  Branch_cdb_tag,
   output logic [DATA_W-1:0] Branch_cdb_data,
   output logic              Branch_cdb_taken,
   output logic [ADDR_W-1:0] Branch_cdb_target,
   output logic              overflow_err
);

   logic                         res_taken;
   logic [ADDR_W-1:0]            res_target;
   logic [DATA_W-1:0]            res_data;

   logic [1:0]                   count_q,    count_d;
   logic                         head_q,     head_d;
   logic                         tail_q,     tail_d;
   logic [1:0]                   valid_q,    valid_d;
   logic [1:0][TAG_W-1:0]        tag_q,      tag_d;
   logic [1:0][DATA_W-1:0]       data_q,     data_d;
   logic [1:0]                   taken_q,    taken_d;
   logic [1:0][ADDR_W-1:0]       target_q,   target_d;
   logic                         overflow_q, overflow_d;
   logic                         do_push;
   logic                         do_pop;
   logic                         is_full;

   branch_resolve #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .OP_W   (OP_W)
   ) u_resolve (
      .op     (Branch_op),
      .reg1   (Branch_reg1),
      .reg2   (Branch_reg2),
      .imm    (Branch_imm),
      .pc     (Branch_pc),
      .taken  (res_taken),
      .target (res_target),
      .data   (res_data)
   );

   assign is_full = (count_q == 2'(QDEPTH));
   assign do_pop  = rdy && !clear && valid_q[head_q] && cdb_grant;
   assign do_push = rdy && !clear && Branch_valid && (!is_full || do_pop);

   always_comb begin
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      data_d     = data_q;
      taken_d    = taken_q;
      target_d   = target_q;
      overflow_d = overflow_q;
      if (rdy && clear) begin
         count_d = '0;
         head_d  = 1'b0;
         tail_d  = 1'b0;
         valid_d = '0;
      end else begin
         if (rdy && Branch_valid && is_full && !do_pop) overflow_d = 1'b1;
         // Pop before push: at count 2 the freed head slot is the tail being written.
         if (do_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = ~head_q;
         end
         if (do_push) begin
            valid_d[tail_q]  = 1'b1;
            tag_d[tail_q]    = Branch_reg_des_rob;
            data_d[tail_q]   = res_data;
            taken_d[tail_q]  = res_taken;
            target_d[tail_q] = res_target;
            tail_d           = ~tail_q;
         end
         count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   // NOTE: entry storage is reset too, because the CDB fields are read straight from it
   // and must be zero out of reset; state updates use non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q    <= '0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         valid_q    <= '0;
         tag_q      <= '0;
         data_q     <= '0;
         taken_q    <= '0;
         target_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         data_q     <= data_d;
         taken_q    <= taken_d;
         target_q   <= target_d;
         overflow_q <= overflow_d;
      end
   end

   assign bu_full           = (count_q != 2'd0);
   assign Branch_cdb_valid  = valid_q[head_q];
   assign Branch_cdb_tag    = tag_q[head_q];
   assign Branch_cdb_data   = data_q[head_q];
   assign Branch_cdb_taken  = taken_q[head_q];
   assign Branch_cdb_target = target_q[head_q];
   assign overflow_err      = overflow_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit: resolve table, queue back-pressure,
// overflow, push+pop at full, clear, rdy freeze and asynchronous reset.
module tb_branch_unit;
   import branch_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        clear;
   logic        Branch_valid;
   logic [5:0]  Branch_op;
   logic [31:0] Branch_reg1;
   logic [31:0] Branch_reg2;
   logic [31:0] Branch_imm;
   logic [31:0] Branch_pc;
   logic [3:0]  Branch_reg_des_rob;
   logic        bu_full;
   logic        cdb_grant;
   logic        Branch_cdb_valid;
   logic [3:0]  Branch_cdb_tag;
   logic [31:0] Branch_cdb_data;
   logic        Branch_cdb_taken;
   logic [31:0] Branch_cdb_target;
   logic        overflow_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
      logic [31:0] data;
   } vec_t;

   vec_t vecs [11];

   branch_unit dut (
      .clk                (clk),
      .rst                (rst),
      .rdy                (rdy),
      .clear              (clear),
      .Branch_valid       (Branch_valid),
      .Branch_op          (Branch_op),
      .Branch_reg1        (Branch_reg1),
      .Branch_reg2        (Branch_reg2),
      .Branch_imm         (Branch_imm),
      .Branch_pc          (Branch_pc),
      .Branch_reg_des_rob (Branch_reg_des_rob),
      .bu_full            (bu_full),
      .cdb_grant          (cdb_grant),
      .Branch_cdb_valid   (Branch_cdb_valid),
      .Branch_cdb_tag     (Branch_cdb_tag),
      .Branch_cdb_data    (Branch_cdb_data),
      .Branch_cdb_taken   (Branch_cdb_taken),
      .Branch_cdb_target  (Branch_cdb_target),
      .overflow_err       (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
      Branch_valid       = 1'b1;
      Branch_op          = op;
      Branch_reg1        = r1;
      Branch_reg2        = r2;
      Branch_imm         = imm;
      Branch_pc          = pc;
      Branch_reg_des_rob = tag;
   endtask

   task automatic check_head(input string name, input logic [3:0] tag,
                             input logic [31:0] target);
      check({name, "_valid"},  64'(Branch_cdb_valid), 64'(1));
      check({name, "_tag"},    64'(Branch_cdb_tag), 64'(tag));
      check({name, "_target"}, 64'(Branch_cdb_target), 64'(target));
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_valid"},    64'(Branch_cdb_valid), 64'(0));
      check({name, "_tag"},      64'(Branch_cdb_tag), 64'(0));
      check({name, "_data"},     64'(Branch_cdb_data), 64'(0));
      check({name, "_taken"},    64'(Branch_cdb_taken), 64'(0));
      check({name, "_target"},   64'(Branch_cdb_target), 64'(0));
      check({name, "_full"},     64'(bu_full), 64'(0));
      check({name, "_overflow"}, 64'(overflow_err), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //              op       r1            r2     imm           pc            tk  target        data
      vecs[0]  = '{OP_BEQ,  32'd5,        32'd5, 32'h20,       32'h100,      1'b1, 32'h120,  32'h0};
      vecs[1]  = '{OP_BLT,  32'hFFFFFFFF, 32'd1, 32'h8,        32'h10,       1'b1, 32'h18,   32'h0};
      vecs[2]  = '{OP_BLTU, 32'hFFFFFFFF, 32'd1, 32'h8,        32'h200,      1'b0, 32'h204,  32'h0};
      vecs[3]  = '{OP_JALR, 32'h1001,     32'd0, 32'h2,        32'h300,      1'b1, 32'h1002, 32'h304};
      vecs[4]  = '{OP_JAL,  32'd0,        32'd0, 32'hFFFFFFF0, 32'h400,      1'b1, 32'h3F0,  32'h404};
      vecs[5]  = '{OP_BGE,  32'hFFFFFFFF, 32'd1, 32'h40,       32'h20,       1'b0, 32'h24,   32'h0};
      vecs[6]  = '{OP_BGEU, 32'hFFFFFFFF, 32'd1, 32'h40,       32'h20,       1'b1, 32'h60,   32'h0};
      vecs[7]  = '{OP_BNE,  32'd7,        32'd7, 32'h10,       32'h30,       1'b0, 32'h34,   32'h0};
      vecs[8]  = '{6'h3F,   32'd1,        32'd1, 32'h10,       32'h40,       1'b0, 32'h44,   32'h0};
      vecs[9]  = '{OP_JAL,  32'd0,        32'd0, 32'h8,        32'hFFFFFFFC, 1'b1, 32'h4,    32'h0};
      vecs[10] = '{OP_BEQ,  32'd5,        32'd6, 32'h20,       32'h50,       1'b0, 32'h54,   32'h0};

      rst = 1'b0;
      rdy = 1'b1;
      clear = 1'b0;
      cdb_grant = 1'b0;
      Branch_valid = 1'b0;
      Branch_op = '0;
      Branch_reg1 = '0;
      Branch_reg2 = '0;
      Branch_imm = '0;
      Branch_pc = '0;
      Branch_reg_des_rob = '0;
      #12;
      check_all_zero("reset");
      rst = 1'b1;
      step();

      // Resolve table: each result appears one edge after issue and is popped on the next.
      cdb_grant = 1'b1;
      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].imm, vecs[i].pc, 4'(i + 1));
         step();
         Branch_valid = 1'b0;
         check($sformatf("vec%0d_valid", i),  64'(Branch_cdb_valid), 64'(1));
         check($sformatf("vec%0d_tag", i),    64'(Branch_cdb_tag), 64'(i + 1));
         check($sformatf("vec%0d_taken", i),  64'(Branch_cdb_taken), 64'(vecs[i].taken));
         check($sformatf("vec%0d_target", i), 64'(Branch_cdb_target), 64'(vecs[i].target));
         check($sformatf("vec%0d_data", i),   64'(Branch_cdb_data), 64'(vecs[i].data));
         check($sformatf("vec%0d_full", i),   64'(bu_full), 64'(1));
         step();
         check($sformatf("vec%0d_popped", i), 64'(Branch_cdb_valid), 64'(0));
         check($sformatf("vec%0d_empty", i),  64'(bu_full), 64'(0));
      end

      // Back-pressure: two entries held, a third is dropped and flags overflow.
      cdb_grant = 1'b0;
      issue(OP_BEQ, 32'd1, 32'd1, 32'h10, 32'h500, 4'd1);
      step();
      check_head("bp_first", 4'd1, 32'h510);
      check("bp_full1", 64'(bu_full), 64'(1));
      issue(OP_BNE, 32'd1, 32'd2, 32'h40, 32'h600, 4'd2);
      step();
      check_head("bp_hold", 4'd1, 32'h510);
      check("bp_no_ovf", 64'(overflow_err), 64'(0));
      issue(OP_BEQ, 32'd1, 32'd1, 32'h80, 32'h700, 4'd5);
      step();
      Branch_valid = 1'b0;
      check("bp_ovf", 64'(overflow_err), 64'(1));
      check_head("bp_still_first", 4'd1, 32'h510);
      cdb_grant = 1'b1;
      step();
      check_head("bp_second", 4'd2, 32'h640);
      step();
      check("bp_drained", 64'(Branch_cdb_valid), 64'(0));
      check("bp_drained_full", 64'(bu_full), 64'(0));

      // Push and pop on the same edge with the queue full.
      cdb_grant = 1'b0;
      issue(OP_JAL, 32'd0, 32'd0, 32'h100, 32'h800, 4'd6);
      step();
      issue(OP_JAL, 32'd0, 32'd0, 32'h200, 32'h800, 4'd7);
      step();
      check_head("pp_pre", 4'd6, 32'h900);
      issue(OP_JAL, 32'd0, 32'd0, 32'h300, 32'h800, 4'd8);
      cdb_grant = 1'b1;
      step();
      Branch_valid = 1'b0;
      check_head("pp_after", 4'd7, 32'hA00);
      check("pp_full", 64'(bu_full), 64'(1));
      step();
      check_head("pp_third", 4'd8, 32'hB00);
      check("pp_ovf_sticky", 64'(overflow_err), 64'(1));
      step();
      check("pp_drained", 64'(Branch_cdb_valid), 64'(0));

      // Clear together with an issue and a grant.
      cdb_grant = 1'b0;
      issue(OP_BEQ, 32'd3, 32'd3, 32'h4, 32'h900, 4'd9);
      step();
      check_head("clr_pre", 4'd9, 32'h904);
      issue(OP_BEQ, 32'd3, 32'd3, 32'h8, 32'h900, 4'd10);
      cdb_grant = 1'b1;
      clear = 1'b1;
      step();
      clear = 1'b0;
      Branch_valid = 1'b0;
      check("clr_valid", 64'(Branch_cdb_valid), 64'(0));
      check("clr_full", 64'(bu_full), 64'(0));
      check("clr_ovf_kept", 64'(overflow_err), 64'(1));
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("clr_quiet%0d", i), 64'(Branch_cdb_valid), 64'(0));
      end

      // rdy low freezes state; then asynchronous reset between edges.
      cdb_grant = 1'b0;
      issue(OP_JAL, 32'd0, 32'd0, 32'h8, 32'h700, 4'd11);
      step();
      check_head("rdy_pre", 4'd11, 32'h708);
      rdy = 1'b0;
      cdb_grant = 1'b1;
      issue(OP_BEQ, 32'd0, 32'd0, 32'h4, 32'h10, 4'd12);
      for (int i = 0; i < 3; i++) begin
         step();
         check_head($sformatf("rdy_hold%0d", i), 4'd11, 32'h708);
         check($sformatf("rdy_data%0d", i), 64'(Branch_cdb_data), 64'(32'h704));
      end
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      Branch_valid = 1'b0;
      rdy = 1'b1;
      #1;
      rst = 1'b1;
      step();
      check("post_rst_valid", 64'(Branch_cdb_valid), 64'(0));
      check("post_rst_full", 64'(bu_full), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
